// File: rtl/rs232in_fifo.sv
// Receive-side byte FIFO behind the rs232in UART receiver: show-ahead valid/ready output,
// sticky overrun flag and saturating drop counter. Define RS232IN_FIFO_AFULL_EN for almost_full.
module rs232in_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  attention,
    input  logic [7:0]            received_data,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  overrun_clear,
    output logic [7:0]            drop_count
`ifdef RS232IN_FIFO_AFULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 10 || AFULL_LEVEL < 0) begin : g_param_check
        $error("rs232in_fifo: DEPTH_LOG2 must be 1..10 and AFULL_LEVEL non-negative");
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic empty, full, push, pop, drop;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
        pop   = rd_valid_q & rd_ready;
        push  = attention & (~full | pop);
        drop  = attention & full & ~pop;

        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
        count_d = wptr_d - rptr_d;
        rd_valid_d = (wptr_d != rptr_d);

        // The new head may be the byte being written this very edge, which the array cannot return yet.
        if (wptr_d == rptr_d) begin
            rd_data_d = rd_data_q;
        end else if (push && (wptr_q == rptr_d)) begin
            rd_data_d = received_data;
        end else begin
            rd_data_d = mem[rptr_d[PW-2:0]];
        end

        overrun_d    = overrun_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overrun_d    = 1'b1;
            drop_count_d = overrun_clear ? 8'd1
                         : (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
        end else if (overrun_clear) begin
            overrun_d    = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr_q[PW-2:0]] <= received_data;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers see pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef RS232IN_FIFO_AFULL_EN
    logic almost_full_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (32'(count_d) >= 32'(AFULL_LEVEL));
        end
    end

    assign almost_full = almost_full_q;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign count      = count_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo: vector table for the basic push/drain flow, plus a
// byte scoreboard and flag model for overflow, overrun_clear, saturation and async reset.
module tb_rs232in_fifo;

    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int AFULL_LEVEL = 12;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                attention;
    logic [7:0]          received_data;
    logic [7:0]          rd_data;
    logic                rd_valid;
    logic                rd_ready;
    logic [DEPTH_LOG2:0] count;
    logic                overrun;
    logic                overrun_clear;
    logic [7:0]          drop_count;
`ifdef RS232IN_FIFO_AFULL_EN
    logic                almost_full;
`endif

    rs232in_fifo #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .attention     (attention),
        .received_data (received_data),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .count         (count),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .drop_count    (drop_count)
`ifdef RS232IN_FIFO_AFULL_EN
        ,
        .almost_full   (almost_full)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];
    bit         m_ovr;
    int         m_drop;

    typedef struct {
        bit         att;
        logic [7:0] data;
        bit         rdy;
        int         exp_count;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(sb.size()));
        check("rd_valid", 32'(rd_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) check("head", 32'(rd_data), 32'(sb[0]));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("drop_count", 32'(drop_count), 32'(m_drop));
`ifdef RS232IN_FIFO_AFULL_EN
        check("almost_full", 32'(almost_full), 32'(sb.size() >= AFULL_LEVEL));
`endif
    endtask

    // One clock: drive inputs, score the pop, step the model, then check outputs after the edge.
    task automatic cycle(input bit att, input logic [7:0] data, input bit rdy, input bit clr);
        bit pop, push, drop;
        attention     = att;
        received_data = data;
        rd_ready      = rdy;
        overrun_clear = clr;
        pop  = (sb.size() > 0) && rdy;
        push = att && ((sb.size() < DEPTH) || pop);
        drop = att && (sb.size() == DEPTH) && !pop;
        if (pop) check("pop_data", 32'(rd_data), 32'(sb[0]));
        @(posedge clock);
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back(data);
        if (drop) begin
            m_ovr  = 1'b1;
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (clr) begin
            m_ovr  = 1'b0;
            m_drop = 0;
        end
        #1;
        attention     = 1'b0;
        rd_ready      = 1'b0;
        overrun_clear = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
`ifdef RS232IN_FIFO_AFULL_EN
        check("rst_almost_full", 32'(almost_full), 32'd0);
`endif
        sb.delete();
        m_ovr  = 1'b0;
        m_drop = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        attention     = 1'b0;
        received_data = 8'h00;
        rd_ready      = 1'b0;
        overrun_clear = 1'b0;
        reset_n       = 1'b1;
        #1;

        // Three strobes five cycles apart, then a continuous drain.
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1, 1'b1, 8'h41};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h41};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h41};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h41};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h41};
        vecs[5]  = '{1'b1, 8'h42, 1'b0, 2, 1'b1, 8'h41};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h41};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h41};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h41};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h41};
        vecs[10] = '{1'b1, 8'h43, 1'b0, 3, 1'b1, 8'h41};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h42};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h43};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].att, vecs[i].data, vecs[i].rdy, 1'b0);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
        end

        // Fill to full, overflow by two, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd2);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained_valid", 32'(rd_valid), 32'd0);

        // Push and pop together while full: no drop, 0x99 comes out last.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_drop_count", 32'(drop_count), 32'd2);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("last_is_99", 32'(rd_data), 32'h99);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // overrun_clear alone, then colliding with a drop, then saturation.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_drop_count", 32'(drop_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0, 1'b1);
        check("clr_drop_overrun", 32'(overrun), 32'd1);
        check("clr_drop_count1", 32'(drop_count), 32'd1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("sat_drop_count", 32'(drop_count), 32'd255);

        // Asynchronous reset with five bytes still queued.
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_valid", 32'(rd_valid), 32'd0);

`ifdef RS232IN_FIFO_AFULL_EN
        for (int i = 0; i < AFULL_LEVEL - 1; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("afull_below", 32'(almost_full), 32'd0);
        cycle(1'b1, 8'h7F, 1'b0, 1'b0);
        check("afull_at_level", 32'(almost_full), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("afull_after_pop", 32'(almost_full), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
